amo_lrsc_shim: RTL
==================

# amo_lrsc_shim

Parametrised atomic-memory shim placed directly in front of a single-ported SRAM bank, with exclusive ownership of that bank. It passes plain loads and stores through, performs 32-bit read-modify-write AMOs on any 32-bit lane of a DataWidth-wide row, and tracks per-hart LR/SC reservations. It replaces the fixed 64-bit AMO shim in banks that serve several harts.

## Interface
- AddrMemWidth, 32: row address width.
- DataWidth, 64: row width; multiple of 32, ≥64; NumLanes = DataWidth/32.
- NumHarts, 4: reservation slots; HartIdWidth = max(1, $clog2(NumHarts)).
- clk_i  in  1  clock.
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low.
- in_req_i  in  1  bank request.
- in_gnt_o  out  1  bank grant.
- in_add_i  in  AddrMemWidth  row address.
- in_amo_i  in  4  op: 0 none, 1 swap, 2 add, 3 and, 4 or, 5 xor, 6 max, 7 maxu, 8 min, 9 minu, A cas, B lr, C sc; others act as none.
- in_wen_i  in  1  1 store, 0 load (ignored when in_amo_i ≠ 0).
- in_hart_i  in  HartIdWidth  requesting hart.
- in_wdata_i  in  DataWidth  write data / operand.
- in_be_i  in  DataWidth/8  byte enables.
- in_rdata_o  out  DataWidth  read data.
- in_rvalid_o  out  1  read data valid.
- out_req_o, out_add_o, out_wen_o, out_wdata_o, out_be_o  out  SRAM side, same widths as the in_ counterparts.
- out_rdata_i  in  DataWidth  SRAM read data, one cycle after out_req_o.

## Operation
- States: Idle, DoAMO.
- Idle: all out_* mirror in_*; in_gnt_o = in_req_i; in_rdata_o = out_rdata_i.
- Lane k = index of the lowest 4-byte group whose bit be[4k] is set; operand B = in_wdata_i lane k.
- Ops 1–A, granted in Idle: read issued (out_wen_o=0); latch op, addr, k, and B; CAS swap value = wdata lane (k+1) mod NumLanes; go to DoAMO.
- DoAMO:
  - in_gnt_o=0, out_req_o=1, out_wen_o=1, out_add_o=latched addr.
  - out_be_o = lane k only; out_wdata_o = result in lane k, other lanes 0.
  - in_rdata_o = old value A in lane k, other lanes 0.
  - Always returns to Idle.
- Arithmetic: add wraps mod 2^32. max/min use signed 32-bit compare; maxu/minu unsigned; ties select A. CAS writes the swap value if A==B, else rewrites A.
- LR: plain load; sets slot[in_hart_i] = {valid, addr}.
- SC: if slot[hart] is valid and addr matches, forwarded as a store; lane k of in_rdata_o = 0. Otherwise out_req_o forced 0 and lane k = 1. Either way slot[hart] is cleared.
- Any committed write (store, AMO write, successful SC) clears every valid slot whose addr equals the written row, including the writer's own slot.
- Reservation granularity is one row.

## Timing
- Reset (async, immediate): state Idle, all slots invalid, in_rvalid_o=0, latched op/addr/operands 0.
- Combinational outputs during reset follow the Idle feed-through.
- in_rvalid_o = 1 exactly one cycle after each grant (loads, stores, LR, SC, AMO). Store rdata content is don't-care.
- AMO: grant at T; old value plus write at T+1; next grant no earlier than T+2. A request held during DoAMO waits.
- LR/SC/load/store: single cycle, back-to-back grants allowed.
- Same-cycle reservation clear and LR to the same row: LR wins (slot ends valid).
- Reset asserted during DoAMO: write not issued; memory keeps its old value.

## Configuration
- AMO_SHIM_LRSC_EN defined: reservation slots and SC failure path are built.
- AMO_SHIM_LRSC_EN undefined:
  - No slot storage.
  - LR behaves as a plain load.
  - SC behaves as a plain store that always returns 0 in lane k.
  - in_hart_i is unused.

## Test plan
- Add, DataWidth=64: mem row 5 = {0x1, 0xFFFFFFFF}, amo=2, be=0x0F, wdata lo=1 → rdata lo 0xFFFFFFFF at T+1; row becomes {0x1, 0x0}; gnt low at T+1.
- Upper-lane CAS, DataWidth=128: row lane 2 = 7, be lane 2 only, wdata lane 2 = 7, lane 3 = 9 → lane 2 becomes 9, rdata lane 2 = 7. Repeat with compare value 8 → row unchanged.
- Signed/unsigned: A = 0x80000000, B = 1. max → 1; maxu → 0x80000000; min → 0x80000000; minu → 1.
- LR/SC success: hart 1 LR row 3, then SC row 3 → write performed, rdata 0. Second SC → no out_req_o, rdata 1.
- Reservation kill: hart 0 and hart 2 LR row 8; hart 3 stores row 8; both SCs fail (rdata 1), memory holds hart 3's data.
- Reset mid-AMO: assert rst_ni low during DoAMO → no write, row unchanged, in_rvalid_o=0, slots invalid; next AMO completes normally.

Source files
------------

// File: rtl/amo_lrsc_shim.sv
// Atomic-memory shim in front of a single-ported SRAM bank: load/store feed-through, 32-bit lane AMOs, LR/SC.
// Define AMO_SHIM_LRSC_EN to build the per-hart reservation slots and the SC failure path.
module amo_lrsc_shim #(
    parameter int unsigned AddrMemWidth = 32,
    parameter int unsigned DataWidth    = 64,
    parameter int unsigned NumHarts     = 4
) (
    input  logic                                               clk_i,
    input  logic                                               rst_ni,
    input  logic                                               in_req_i,
    output logic                                               in_gnt_o,
    input  logic [AddrMemWidth-1:0]                            in_add_i,
    input  logic [3:0]                                         in_amo_i,
    input  logic                                               in_wen_i,
    input  logic [((NumHarts > 1) ? $clog2(NumHarts) : 1)-1:0] in_hart_i,
    input  logic [DataWidth-1:0]                               in_wdata_i,
    input  logic [DataWidth/8-1:0]                             in_be_i,
    output logic [DataWidth-1:0]                               in_rdata_o,
    output logic                                               in_rvalid_o,
    output logic                                               out_req_o,
    output logic [AddrMemWidth-1:0]                            out_add_o,
    output logic                                               out_wen_o,
    output logic [DataWidth-1:0]                               out_wdata_o,
    output logic [DataWidth/8-1:0]                             out_be_o,
    input  logic [DataWidth-1:0]                               out_rdata_i
);
    localparam int unsigned NumLanes = DataWidth / 32;
    localparam int unsigned LaneW    = (NumLanes > 1) ? $clog2(NumLanes) : 1;

    localparam logic [3:0] OpSwap = 4'h1, OpAdd = 4'h2, OpAnd = 4'h3, OpOr = 4'h4, OpXor = 4'h5;
    localparam logic [3:0] OpMax = 4'h6, OpMaxu = 4'h7, OpMin = 4'h8, OpMinu = 4'h9;
    localparam logic [3:0] OpCas = 4'hA, OpLr = 4'hB, OpSc = 4'hC;

    typedef enum logic {Idle, DoAmo} state_e;
    state_e state_q, state_d;

    logic [NumLanes-1:0][31:0] wlanes, rlanes, res_lanes, old_lanes, idle_lanes;
    logic [NumLanes-1:0][3:0]  be_sel;
    logic [LaneW-1:0]          lane, lane_q, sc_lane_q;
    logic [31:0]               opb, swp, opb_q, swp_q, opa, res;
    logic [3:0]                op_q;
    logic [AddrMemWidth-1:0]   addr_q;
    logic                      is_amo, is_lr, is_sc, fire, sc_ok;
    logic                      rvalid_q, sc_q, sc_fail_q;

    assign wlanes      = in_wdata_i;
    assign rlanes      = out_rdata_i;
    assign is_amo      = (in_amo_i >= OpSwap) && (in_amo_i <= OpCas);
    assign is_lr       = (in_amo_i == OpLr);
    assign is_sc       = (in_amo_i == OpSc);
    assign fire        = (state_q == Idle) && in_req_i;
    assign in_rvalid_o = rvalid_q;

    // Lowest lane whose first byte enable is set; the CAS swap value sits one lane above (wrapping).
    always_comb begin
        lane = '0;
        opb  = wlanes[0];
        swp  = wlanes[1 % NumLanes];
        for (int i = NumLanes - 1; i >= 0; i--) begin
            if (in_be_i[4*i]) begin
                lane = LaneW'(i);
                opb  = wlanes[i];
                swp  = wlanes[(i + 1) % NumLanes];
            end
        end
    end

    always_comb begin
        opa = rlanes[lane_q];
        res = opa;
        case (op_q)
            OpSwap:  res = opb_q;
            OpAdd:   res = opa + opb_q;
            OpAnd:   res = opa & opb_q;
            OpOr:    res = opa | opb_q;
            OpXor:   res = opa ^ opb_q;
            OpMax:   res = ($signed(opb_q) > $signed(opa)) ? opb_q : opa;
            OpMaxu:  res = (opb_q > opa) ? opb_q : opa;
            OpMin:   res = ($signed(opb_q) < $signed(opa)) ? opb_q : opa;
            OpMinu:  res = (opb_q < opa) ? opb_q : opa;
            OpCas:   res = (opa == opb_q) ? swp_q : opa;
            default: res = opa;
        endcase
    end

    // SC status replaces lane k of the read data in the response cycle.
    always_comb begin
        for (int i = 0; i < NumLanes; i++) begin
            res_lanes[i]  = (LaneW'(i) == lane_q) ? res : 32'h0;
            old_lanes[i]  = (LaneW'(i) == lane_q) ? opa : 32'h0;
            be_sel[i]     = (LaneW'(i) == lane_q) ? 4'hF : 4'h0;
            idle_lanes[i] = (sc_q && (LaneW'(i) == sc_lane_q)) ? {31'h0, sc_fail_q} : rlanes[i];
        end
    end

    always_comb begin
        state_d     = state_q;
        in_gnt_o    = in_req_i;
        out_req_o   = in_req_i;
        out_add_o   = in_add_i;
        out_wen_o   = in_wen_i;
        out_wdata_o = in_wdata_i;
        out_be_o    = in_be_i;
        in_rdata_o  = idle_lanes;
        if (state_q == DoAmo) begin
            in_gnt_o    = 1'b0;
            out_req_o   = 1'b1;
            out_wen_o   = 1'b1;
            out_add_o   = addr_q;
            out_wdata_o = res_lanes;
            out_be_o    = be_sel;
            in_rdata_o  = old_lanes;
            state_d     = Idle;
        end else if (is_amo || is_lr) begin
            out_wen_o = 1'b0;
            if (in_req_i && is_amo) state_d = DoAmo;
        end else if (is_sc) begin
            out_wen_o = 1'b1;
            out_req_o = in_req_i && sc_ok;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= Idle;
            op_q      <= '0;
            addr_q    <= '0;
            lane_q    <= '0;
            opb_q     <= '0;
            swp_q     <= '0;
            rvalid_q  <= 1'b0;
            sc_q      <= 1'b0;
            sc_fail_q <= 1'b0;
            sc_lane_q <= '0;
        end else begin
            state_q   <= state_d;
            rvalid_q  <= in_req_i && in_gnt_o;
            sc_q      <= fire && is_sc;
            sc_fail_q <= !sc_ok;
            sc_lane_q <= lane;
            if (fire && is_amo) begin
                op_q   <= in_amo_i;
                addr_q <= in_add_i;
                lane_q <= lane;
                opb_q  <= opb;
                swp_q  <= swp;
            end
        end
    end

`ifdef AMO_SHIM_LRSC_EN
    localparam int unsigned HartW = (NumHarts > 1) ? $clog2(NumHarts) : 1;

    logic [NumHarts-1:0]                   slot_vld_q;
    logic [NumHarts-1:0][AddrMemWidth-1:0] slot_add_q;
    logic                                  wr_commit;

    assign sc_ok     = slot_vld_q[in_hart_i] && (slot_add_q[in_hart_i] == in_add_i);
    assign wr_commit = out_req_o && out_wen_o;

    // Later assignment wins: an LR in the same cycle as a kill leaves the slot valid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_vld_q <= '0;
            slot_add_q <= '0;
        end else begin
            for (int h = 0; h < NumHarts; h++) begin
                if (wr_commit && (slot_add_q[h] == out_add_o)) slot_vld_q[h] <= 1'b0;
                if (fire && (is_sc || is_lr) && (in_hart_i == HartW'(h))) begin
                    slot_vld_q[h] <= is_lr;
                    if (is_lr) slot_add_q[h] <= in_add_i;
                end
            end
        end
    end
`else
    logic unused_hart;
    assign unused_hart = ^in_hart_i;
    assign sc_ok       = 1'b1;
`endif
endmodule
